// File: rtl/trace_capture_if.sv
// Trace stream bundle: head-of-FIFO entry plus valid/ready handshake.
//   master : producer side (trace_capture), drives valid and entry fields
//   slave  : consumer side (monitor / debug port), drives ready
interface trace_capture_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned SEQ_W      = 16
);

  logic                  trc_valid;
  logic                  trc_ready;
  logic                  trc_kind;
  logic [DM_ADDRESS-1:0] trc_tag;
  logic [DATA_W-1:0]     trc_data;
  logic [SEQ_W-1:0]      trc_seq;

  modport master (
    output trc_valid,
    output trc_kind,
    output trc_tag,
    output trc_data,
    output trc_seq,
    input  trc_ready
  );

  modport slave (
    input  trc_valid,
    input  trc_kind,
    input  trc_tag,
    input  trc_data,
    input  trc_seq,
    output trc_ready
  );

endinterface

// File: rtl/trace_capture.sv
// Captures committed register-file and data-memory writes, numbers each one,
// buffers them in a FIFO and drains them as a first-word-fall-through stream.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              capture enable (draining continues when low)
//   reg_write_sig/reg_num/reg_data   WB-stage register write
//   wr/addr/wr_data     MEM-stage data memory write
//   trc                 trace stream (master modport)
//   count               FIFO occupancy
//   drop_cnt            saturating count of events lost to a full FIFO
// DEPTH must be a power of two and at least 4.
module trace_capture #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SEQ_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      reg_write_sig,
  input  logic [4:0]                reg_num,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic                      wr,
  input  logic [DM_ADDRESS-1:0]     addr,
  input  logic [DATA_W-1:0]         wr_data,
  trace_capture_if.master           trc,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Entry layout, MSB first: kind | tag | data | seq
  localparam int unsigned ENT_W = 1 + DM_ADDRESS + DATA_W + SEQ_W;

  logic [ENT_W-1:0] store [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [SEQ_W-1:0] seq_q;
  logic             valid_q;
  logic [ENT_W-1:0] head_ent_q;

  logic             reg_ev, mem_ev, pop;
  logic [1:0]       n_ev, n_push, n_drop;
  logic [CNT_W-1:0] free_c, remain_c, count_n;
  logic [PTR_W-1:0] head_n, tail_n;
  logic [SEQ_W-1:0] seq_n;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_n;
  logic [ENT_W-1:0] ent_reg, ent_mem, ent0, ent1, head_ent_n;
  logic             valid_n;

  // Event qualification, ordering, space allocation and next-state computation
  always_comb begin
    reg_ev     = enable && reg_write_sig && (reg_num != 5'd0);
    mem_ev     = enable && wr;
    n_ev       = 2'(reg_ev) + 2'(mem_ev);
    free_c     = CNT_W'(DEPTH) - count;
    pop        = valid_q && trc.trc_ready;

    // Space is judged before this cycle's pop: a pop never funds a same-cycle push
    n_push = 2'd0;
    if (free_c >= CNT_W'(2)) begin
      n_push = n_ev;
    end else if (free_c == CNT_W'(1)) begin
      n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
    end
    n_drop = n_ev - n_push;

    // Register event comes first in order and takes the lower sequence number
    ent_reg = {1'b0, DM_ADDRESS'(reg_num), reg_data, seq_q};
    ent_mem = {1'b1, addr, wr_data, seq_q + SEQ_W'(reg_ev)};
    ent0    = reg_ev ? ent_reg : ent_mem;
    ent1    = ent_mem;

    seq_n   = seq_q + SEQ_W'(n_ev);
    count_n = count + CNT_W'(n_push) - CNT_W'(pop);
    head_n  = head_q + PTR_W'(pop);
    tail_n  = tail_q + PTR_W'(n_push);

    drop_sum = 9'(drop_cnt) + 9'(n_drop);
    drop_n   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

    // Next head: an older stored entry if one survives the pop, else the first push
    remain_c   = count - CNT_W'(pop);
    head_ent_n = '0;
    if (remain_c != '0) begin
      head_ent_n = store[head_n];
    end else if (n_push != 2'd0) begin
      head_ent_n = ent0;
    end
    valid_n = (count_n != '0);
  end

  // Control state and registered stream outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count      <= '0;
      seq_q      <= '0;
      drop_cnt   <= '0;
      valid_q    <= 1'b0;
      head_ent_q <= '0;
    end else begin
      head_q     <= head_n;
      tail_q     <= tail_n;
      count      <= count_n;
      seq_q      <= seq_n;
      drop_cnt   <= drop_n;
      valid_q    <= valid_n;
      head_ent_q <= head_ent_n;
    end
  end

  // Storage is not reset; pointers and count define which entries are live
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      store[tail_q] <= ent0;
    end
    if (n_push == 2'd2) begin
      store[tail_q + PTR_W'(1)] <= ent1;
    end
  end

  assign trc.trc_valid = valid_q;
  assign trc.trc_kind  = head_ent_q[ENT_W-1];
  assign trc.trc_tag   = head_ent_q[ENT_W-2 -: DM_ADDRESS];
  assign trc.trc_data  = head_ent_q[SEQ_W +: DATA_W];
  assign trc.trc_seq   = head_ent_q[SEQ_W-1:0];

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DM_ADDRESS = 9;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned SEQ_W      = 16;
  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  enable = 1'b0;
  logic                  reg_write_sig = 1'b0;
  logic [4:0]            reg_num = '0;
  logic [DATA_W-1:0]     reg_data = '0;
  logic                  wr = 1'b0;
  logic [DM_ADDRESS-1:0] addr = '0;
  logic [DATA_W-1:0]     wr_data = '0;
  logic                  ready = 1'b0;
  logic [CNT_W-1:0]      count;
  logic [7:0]            drop_cnt;

  trace_capture_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .SEQ_W(SEQ_W)) trc();
  assign trc.trc_ready = ready;

  trace_capture #(
    .DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .reg_write_sig(reg_write_sig),
    .reg_num(reg_num),
    .reg_data(reg_data),
    .wr(wr),
    .addr(addr),
    .wr_data(wr_data),
    .trc(trc),
    .count(count),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus sequence and drop counters
  typedef struct {
    bit          kind;
    int unsigned tag;
    int unsigned data;
    int unsigned seq;
  } ev_t;

  ev_t         mq[$];
  int unsigned mseq;
  int unsigned mdrop;
  int          mfree;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_event(input bit kind, input int unsigned tag, input int unsigned data);
    ev_t e;
    e.kind = kind;
    e.tag  = tag;
    e.data = data;
    e.seq  = mseq;
    mseq   = (mseq + 1) % (1 << SEQ_W);
    if (mfree > 0) begin
      mq.push_back(e);
      mfree--;
    end else if (mdrop < 255) begin
      mdrop++;
    end
  endtask

  task automatic model_step();
    bit do_pop;
    do_pop = (mq.size() != 0) && ready;
    mfree  = DEPTH - mq.size();
    if (enable) begin
      if (reg_write_sig && reg_num != 0) model_event(1'b0, int'(reg_num), int'(reg_data));
      if (wr) model_event(1'b1, int'(addr), int'(wr_data));
    end
    if (do_pop) void'(mq.pop_front());
  endtask

  task automatic compare();
    chk("valid", 64'(trc.trc_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    if (mq.size() != 0) begin
      chk("kind", 64'(trc.trc_kind), 64'(mq[0].kind));
      chk("tag", 64'(trc.trc_tag), 64'(mq[0].tag));
      chk("data", 64'(trc.trc_data), 64'(mq[0].data));
      chk("seq", 64'(trc.trc_seq), 64'(mq[0].seq));
    end
  endtask

  // One clock: inputs already set at the previous negedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_ev();
    reg_write_sig = 1'b0;
    wr            = 1'b0;
  endtask

  task automatic set_reg(input int unsigned n, input int unsigned d);
    reg_write_sig = 1'b1;
    reg_num       = 5'(n);
    reg_data      = DATA_W'(d);
  endtask

  task automatic set_mem(input int unsigned a, input int unsigned d);
    wr      = 1'b1;
    addr    = DM_ADDRESS'(a);
    wr_data = DATA_W'(d);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    clear_ev();
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(trc.trc_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_kind", 64'(trc.trc_kind), 64'(0));
    chk("rst_tag", 64'(trc.trc_tag), 64'(0));
    chk("rst_data", 64'(trc.trc_data), 64'(0));
    chk("rst_seq", 64'(trc.trc_seq), 64'(0));
    mq.delete();
    mseq  = 0;
    mdrop = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    enable = 1'b1;

    // Single register write, stalled consumer
    ready = 1'b0;
    set_reg(5, 32'h0000_00AA);
    cycle();
    clear_ev();
    chk("t1_valid", 64'(trc.trc_valid), 64'(1));
    chk("t1_kind", 64'(trc.trc_kind), 64'(0));
    chk("t1_tag", 64'(trc.trc_tag), 64'(5));
    chk("t1_data", 64'(trc.trc_data), 64'(32'hAA));
    chk("t1_seq", 64'(trc.trc_seq), 64'(0));
    chk("t1_count", 64'(count), 64'(1));
    ready = 1'b1;
    cycle();

    // Simultaneous reg and mem events: reg ordered first
    do_reset();
    ready = 1'b1;
    set_reg(3, 32'h11);
    set_mem(9'h040, 32'h22);
    cycle();
    clear_ev();
    chk("t2_kind0", 64'(trc.trc_kind), 64'(0));
    chk("t2_tag0", 64'(trc.trc_tag), 64'(3));
    chk("t2_seq0", 64'(trc.trc_seq), 64'(0));
    chk("t2_count", 64'(count), 64'(2));
    cycle();
    chk("t2_kind1", 64'(trc.trc_kind), 64'(1));
    chk("t2_tag1", 64'(trc.trc_tag), 64'(9'h040));
    chk("t2_data1", 64'(trc.trc_data), 64'(32'h22));
    chk("t2_seq1", 64'(trc.trc_seq), 64'(1));
    cycle();
    chk("t2_empty", 64'(trc.trc_valid), 64'(0));

    // Write to x0 is invisible and unnumbered
    do_reset();
    ready = 1'b0;
    set_reg(0, 32'hFFFF_FFFF);
    cycle();
    clear_ev();
    chk("t3_count", 64'(count), 64'(0));
    chk("t3_valid", 64'(trc.trc_valid), 64'(0));
    set_reg(7, 32'h1);
    cycle();
    clear_ev();
    chk("t3_seq", 64'(trc.trc_seq), 64'(0));
    ready = 1'b1;
    cycle();

    // Fill to one free slot, then overflow
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      set_reg(i + 1, 32'h100 + i);
      cycle();
    end
    set_reg(20, 32'h200);
    set_mem(9'h1AB, 32'h300);
    cycle();
    clear_ev();
    chk("t4_count", 64'(count), 64'(16));
    chk("t4_drop", 64'(drop_cnt), 64'(1));
    for (int i = 0; i < 3; i++) begin
      set_mem(i, 32'h400 + i);
      cycle();
    end
    clear_ev();
    chk("t4_drop2", 64'(drop_cnt), 64'(4));

    // Full with a pop and a push in the same cycle: the push is lost
    ready = 1'b1;
    set_reg(9, 32'h500);
    cycle();
    clear_ev();
    ready = 1'b0;
    chk("t5_count", 64'(count), 64'(15));
    chk("t5_drop", 64'(drop_cnt), 64'(5));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_hold_seq", 64'(trc.trc_seq), 64'(1));
      chk("t5_hold_tag", 64'(trc.trc_tag), 64'(2));
      chk("t5_hold_data", 64'(trc.trc_data), 64'(32'h101));
    end
    ready = 1'b1;
    for (int i = 0; i < 18; i++) cycle();
    chk("t5_drained", 64'(count), 64'(0));

    // Reset with entries in flight
    ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_mem(i, i);
      cycle();
    end
    clear_ev();
    chk("t6_count", 64'(count), 64'(7));
    do_reset();
    set_reg(4, 32'hBEEF);
    cycle();
    clear_ev();
    chk("t6_seq", 64'(trc.trc_seq), 64'(0));
    chk("t6_drop", 64'(drop_cnt), 64'(0));

    // Randomized traffic with varying consumer back-pressure
    for (int i = 0; i < 3000; i++) begin
      int unsigned phase;
      phase         = (i / 200) % 4;
      enable        = ($urandom_range(0, 9) != 0);
      reg_write_sig = $urandom_range(0, 1) == 1;
      reg_num       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      reg_data      = DATA_W'($urandom);
      wr            = $urandom_range(0, 1) == 1;
      addr          = DM_ADDRESS'($urandom);
      wr_data       = DATA_W'($urandom);
      case (phase)
        0: ready = $urandom_range(0, 9) < 8;
        1: ready = $urandom_range(0, 9) < 2;
        2: ready = $urandom_range(0, 1) == 1;
        default: ready = 1'b1;
      endcase
      if (i == 1500) do_reset();
      else cycle();
    end
    clear_ev();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
